// File: rtl/l2_norm_stream.sv
// l2_norm_stream: AXI-Stream L2-norm engine.
// Each accepted beat adds the squares of its LANES signed elements to a
// saturating accumulator. The beat that carries tlast starts a restoring
// square root that produces one result bit per cycle. One result beat is
// emitted per packet.
// Optional feature macro: L2NORM_TKEEP_EN. When it is defined, a lane is
// counted only if its lowest keep bit is set. Otherwise tkeep is ignored.
module l2_norm_stream #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [LANES*ELEM_W-1:0]   io_in_tdata,
    input  logic                      io_in_tvalid,
    input  logic [LANES*ELEM_W/8-1:0] io_in_tkeep,
    input  logic                      io_in_tuser,
    output logic                      io_in_tready,
    input  logic                      io_in_tlast,
    output logic [OUT_W-1:0]          io_out_tdata,
    output logic                      io_out_tvalid,
    output logic                      io_out_tuser,
    output logic [OUT_W/8-1:0]        io_out_tkeep,
    input  logic                      io_out_tready,
    output logic                      io_out_tlast
);

    localparam int HALF  = ACC_W / 2;
    localparam int SQ_W  = 2 * ELEM_W;
    // Headroom for acc + one beat: the carry out is what detects saturation.
    localparam int SUM_W = ACC_W + $clog2(LANES) + 2;
    localparam int CNT_W = $clog2(HALF + 1);
    localparam int REM_W = HALF + 2;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {ACCUM, SQRT, OUTPUT} state_t;

    state_t             state, state_next;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   rad;
    logic [HALF-1:0]    root;
    logic [REM_W-1:0]   rem;

    logic [LANES-1:0]   lane_en;
    logic [SUM_W-1:0]   beat_sum;
    logic [SUM_W-1:0]   sum_wide;
    logic               sat;
    logic [ACC_W-1:0]   acc_add;
    logic [REM_W-1:0]   rem_shift;
    logic [REM_W-1:0]   trial;
    logic [REM_W-1:0]   rem_sub;
    logic               take;

    // The upper remainder bits are never shifted back in, and tuser is
    // defined as ignored. Folding them here keeps them visibly unused.
    logic unused_bits;
    assign unused_bits = ^{io_in_tuser, io_in_tkeep, rem[REM_W-1:HALF]};

    // Unsigned square of a signed element. The most negative value squares exactly.
    function automatic logic [SQ_W-1:0] square(input logic signed [ELEM_W-1:0] v);
        logic signed [SQ_W-1:0] wide;
        wide = SQ_W'(v);
        return wide * wide;
    endfunction

    // Select the lanes that take part in this beat.
    always_comb begin
        lane_en = '1;
`ifdef L2NORM_TKEEP_EN
        for (int i = 0; i < LANES; i++) begin
            lane_en[i] = io_in_tkeep[i*ELEM_W/8];
        end
`endif
    end

    // Sum of squares over the beat, followed by a saturating add into the accumulator.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
                beat_sum = beat_sum + SUM_W'(square(io_in_tdata[i*ELEM_W +: ELEM_W]));
            end
        end
        sum_wide = SUM_W'(acc) + beat_sum;
        sat      = (sum_wide > SUM_W'(ACC_MAX));
        acc_add  = sat ? ACC_MAX : sum_wide[ACC_W-1:0];
    end

    // One restoring square-root step: bring down the next bit pair and
    // subtract the trial value 4*root+1 when it fits.
    always_comb begin
        rem_shift = {rem[HALF-1:0], rad[ACC_W-1 -: 2]};
        trial     = {root, 2'b01};
        take      = (rem_shift >= trial);
        rem_sub   = rem_shift - trial;
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the handshake outputs decoded from the state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_next    = state;
        io_in_tready  = 1'b0;
        io_out_tvalid = 1'b0;
        case (state)
            ACCUM: begin
                io_in_tready = 1'b1;
                if (io_in_tvalid && io_in_tlast) state_next = SQRT;
            end
            SQRT: begin
                if (cnt == '0) state_next = OUTPUT;
            end
            OUTPUT: begin
                io_out_tvalid = 1'b1;
                if (io_out_tready) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    assign io_out_tlast = io_out_tvalid;
    assign io_out_tkeep = '1;

    // Accumulator, overflow flag, root engine and the registered result fields.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register samples the pre-edge values.
            acc          <= '0;
            ovf          <= 1'b0;
            cnt          <= '0;
            rad          <= '0;
            root         <= '0;
            rem          <= '0;
            io_out_tdata <= '0;
            io_out_tuser <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (io_in_tvalid) begin
                        acc <= acc_add;
                        ovf <= ovf | sat;
                        if (io_in_tlast) begin
                            rad  <= acc_add;
                            root <= '0;
                            rem  <= '0;
                            cnt  <= CNT_W'(HALF);
                        end
                    end
                end
                SQRT: begin
                    if (cnt != '0) begin
                        rem  <= take ? rem_sub : rem_shift;
                        root <= {root[HALF-2:0], take};
                        rad  <= {rad[ACC_W-3:0], 2'b00};
                        cnt  <= cnt - CNT_W'(1);
                    end else begin
                        io_out_tdata <= OUT_W'(root);
                        io_out_tuser <= ovf;
                    end
                end
                OUTPUT: begin
                    if (io_out_tready) begin
                        acc <= '0;
                        ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_norm_stream.sv
// Directed testbench for l2_norm_stream with the default parameters.
// The expected values in the keep-mask cases depend on L2NORM_TKEEP_EN.
module tb_l2_norm_stream;

    logic        clock;
    logic        reset;
    logic [63:0] io_in_tdata;
    logic        io_in_tvalid;
    logic [7:0]  io_in_tkeep;
    logic        io_in_tuser;
    logic        io_in_tready;
    logic        io_in_tlast;
    logic [31:0] io_out_tdata;
    logic        io_out_tvalid;
    logic        io_out_tuser;
    logic [3:0]  io_out_tkeep;
    logic        io_out_tready;
    logic        io_out_tlast;

    int n_tests = 0;
    int n_fail  = 0;

    l2_norm_stream #(.LANES(4), .ELEM_W(16), .ACC_W(40), .OUT_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_tdata  (io_in_tdata),
        .io_in_tvalid (io_in_tvalid),
        .io_in_tkeep  (io_in_tkeep),
        .io_in_tuser  (io_in_tuser),
        .io_in_tready (io_in_tready),
        .io_in_tlast  (io_in_tlast),
        .io_out_tdata (io_out_tdata),
        .io_out_tvalid(io_out_tvalid),
        .io_out_tuser (io_out_tuser),
        .io_out_tkeep (io_out_tkeep),
        .io_out_tready(io_out_tready),
        .io_out_tlast (io_out_tlast)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered and left 1 time unit after a rising edge. Presents one beat
    // and holds it until an edge on which tready was high.
    task automatic send_beat(input int a, input int b, input int c, input int d,
                             input logic last, input logic [7:0] keep);
        int guard;
        io_in_tdata  = {16'(d), 16'(c), 16'(b), 16'(a)};
        io_in_tvalid = 1'b1;
        io_in_tlast  = last;
        io_in_tkeep  = keep;
        guard = 0;
        while (!io_in_tready && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 100) check("in_accept_timeout", 1, 0);
        @(posedge clock); #1;
        io_in_tvalid = 1'b0;
        io_in_tlast  = 1'b0;
    endtask

    // Waits for tvalid after the tlast edge and checks latency, the result
    // fields, and that input stays stalled until the result is taken.
    task automatic expect_result(input string tag, input logic [31:0] exp_data, input logic exp_user);
        int n;
        int rdy_high;
        n = 0;
        rdy_high = 0;
        while (!io_out_tvalid && n < 100) begin
            @(posedge clock); #1;
            n++;
            if (io_in_tready) rdy_high++;
        end
        check({tag, "_latency"}, n, 21);
        check({tag, "_in_tready_low"}, rdy_high, 0);
        check({tag, "_tdata"}, io_out_tdata, exp_data);
        check({tag, "_tuser"}, io_out_tuser, exp_user);
        check({tag, "_tlast"}, io_out_tlast, 1);
        if (io_out_tready) begin
            @(posedge clock); #1;
            check({tag, "_tvalid_drop"}, io_out_tvalid, 0);
            check({tag, "_in_tready_back"}, io_in_tready, 1);
        end
    endtask

    initial begin
        int seen;
        reset         = 1'b1;
        io_in_tdata   = '0;
        io_in_tvalid  = 1'b0;
        io_in_tkeep   = 8'hFF;
        io_in_tuser   = 1'b0;
        io_in_tlast   = 1'b0;
        io_out_tready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_tready", io_in_tready, 1);
        check("rst_out_tvalid", io_out_tvalid, 0);
        check("rst_out_tlast", io_out_tlast, 0);
        check("rst_out_tdata", io_out_tdata, 0);
        check("rst_out_tuser", io_out_tuser, 0);
        check("rst_out_tkeep", io_out_tkeep, 4'hF);
        reset = 1'b0;
        @(posedge clock); #1;

        // 3-4-5 triangle in a single beat.
        send_beat(3, 4, 0, 0, 1'b1, 8'hFF);
        expect_result("single", 32'd5, 1'b0);

        // Negative lane: 36 + 64 = 100.
        send_beat(-6, 0, 0, 0, 1'b0, 8'hFF);
        send_beat(0, 8, 0, 0, 1'b1, 8'hFF);
        expect_result("multi_neg", 32'd10, 1'b0);

        // Sum is 8, floor(sqrt 8) = 2.
        send_beat(1, 1, 1, 1, 1'b0, 8'hFF);
        send_beat(1, 1, 1, 1, 1'b1, 8'hFF);
        expect_result("floor8", 32'd2, 1'b0);

        // Backpressure: 25 + 144 = 169, result 13 held for 10 cycles.
        io_out_tready = 1'b0;
        send_beat(5, 12, 0, 0, 1'b1, 8'hFF);
        expect_result("bp", 32'd13, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check("bp_hold_tvalid", io_out_tvalid, 1);
            check("bp_hold_tdata", io_out_tdata, 32'd13);
            check("bp_hold_tuser", io_out_tuser, 0);
            check("bp_in_tready", io_in_tready, 0);
        end
        io_out_tready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_tvalid", io_out_tvalid, 0);
        check("bp_release_in_tready", io_in_tready, 1);

        // Saturation: 256 * 4 * 2^30 = 2^40, which crosses the limit on the tlast beat.
        for (int i = 0; i < 256; i++) begin
            send_beat(-32768, -32768, -32768, -32768, (i == 255), 8'hFF);
        end
        expect_result("sat", 32'h000F_FFFF, 1'b1);
        send_beat(3, 4, 0, 0, 1'b1, 8'hFF);
        expect_result("after_sat", 32'd5, 1'b0);

        // Keep mask: only lanes 0 and 1 have their keep bit set.
        send_beat(3, 4, 100, 100, 1'b1, 8'h0F);
`ifdef L2NORM_TKEEP_EN
        expect_result("keep", 32'd5, 1'b0);
`else
        expect_result("keep", 32'd141, 1'b0);
`endif
        send_beat(7, 0, 0, 0, 1'b1, 8'h00);
`ifdef L2NORM_TKEEP_EN
        expect_result("all_masked", 32'd0, 1'b0);
`else
        expect_result("all_masked", 32'd7, 1'b0);
`endif

        // Reset while the root engine is iterating.
        send_beat(3, 4, 0, 0, 1'b1, 8'hFF);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_in_tready", io_in_tready, 1);
        check("midrst_out_tvalid", io_out_tvalid, 0);
        check("midrst_out_tlast", io_out_tlast, 0);
        check("midrst_out_tdata", io_out_tdata, 0);
        check("midrst_out_tuser", io_out_tuser, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            if (io_out_tvalid) seen++;
        end
        check("midrst_no_result", seen, 0);
        send_beat(0, 0, 0, 5, 1'b1, 8'hFF);
        expect_result("post_rst", 32'd5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_norm_stream.md
# l2_norm_stream

Parametrised AXI-Stream L2-norm engine. It accepts packets of `LANES` signed elements per beat and accumulates the sum of squares across the packet. On `tlast` it computes floor(sqrt(sum)) with a multi-cycle restoring square root, then emits one result beat per packet. It sits between the sample DMA stream and the result stream in the hackathon datapath. It is the multi-lane, backpressure-correct, overflow-flagging generation of the single-word L2 norm block.

## Interface

Parameters:
- `LANES`, 4: elements per input beat.
- `ELEM_W`, 16: signed element width; must be a multiple of 8.
- `ACC_W`, 40: unsigned accumulator width; must be even and ≥ 2*`ELEM_W`.
- `OUT_W`, 32: output data width; must be ≥ `ACC_W`/2 and a multiple of 8.

Ports:
- `clock` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `io_in_tdata` input `LANES`*`ELEM_W`: lane i occupies bits [i*`ELEM_W` +: `ELEM_W`].
- `io_in_tvalid` input 1: input beat valid.
- `io_in_tkeep` input `LANES`*`ELEM_W`/8: byte keep. Lane i is included iff keep bit i*`ELEM_W`/8 is 1 (see Configuration).
- `io_in_tuser` input 1: ignored.
- `io_in_tready` output 1: high only in state ACCUM.
- `io_in_tlast` input 1: last beat of the packet.
- `io_out_tdata` output `OUT_W`: floor(sqrt(acc)), zero-extended.
- `io_out_tvalid` output 1: result valid.
- `io_out_tuser` output 1: accumulator saturated during this packet.
- `io_out_tkeep` output `OUT_W`/8: constant all ones.
- `io_out_tready` input 1: downstream ready.
- `io_out_tlast` output 1: equals `io_out_tvalid`; every result is a one-beat packet.

## Operation

- FSM states: ACCUM, SQRT, OUTPUT. Reset state is ACCUM.
- **ACCUM**
  - Each handshake (`io_in_tvalid` & `io_in_tready`) adds the sum over included lanes of lane², computed as an unsigned 2*`ELEM_W` square of the signed value. (-2^(`ELEM_W`-1))² is exact.
  - The addition saturates at 2^`ACC_W`-1. Saturation sets a sticky `ovf` flag.
  - A handshake with `tlast` set loads the accumulator result into the root engine and moves the FSM to SQRT.
- **SQRT**
  - Restoring bit-pair algorithm, one result bit per cycle, for `ACC_W`/2 cycles. An iteration counter counts down to 0.
  - The result is written to `io_out_tdata`, and `ovf` to `io_out_tuser`. Then the FSM moves to OUTPUT.
- **OUTPUT**
  - `io_out_tvalid`=1, and all output fields are held stable until `io_out_tready`=1.
  - On the out handshake, the FSM clears the accumulator and `ovf` and returns to ACCUM.
- Packet with every lane masked: result 0, `tuser` 0.
- `io_in_tready`=0 in SQRT and OUTPUT. No input is lost or buffered.
- Reset mid-operation: asynchronous reset
  - returns the FSM to ACCUM;
  - clears the accumulator, `ovf` and the counter;
  - drives the outputs to reset values. Any partial packet is discarded.

## Timing

- Reset values:
  - `io_in_tready`=1;
  - `io_out_tvalid`=0, `io_out_tlast`=0;
  - `io_out_tdata`=0, `io_out_tuser`=0;
  - `io_out_tkeep`=all ones.
- Throughput in ACCUM: one beat per cycle.
- Latency: `io_out_tvalid` rises exactly `ACC_W`/2+1 rising edges after the edge that accepts the `tlast` beat. This is 21 edges for the defaults.
- `io_in_tready` falls on the edge that accepts `tlast`. It rises on the edge that completes the out handshake. The first beat of the next packet can be accepted in the following cycle.
- Turnaround: with `io_out_tready` tied high, one packet per (beats + `ACC_W`/2 + 2) cycles.
- Saturation on the `tlast` beat itself is still reflected in `io_out_tuser`.

## Configuration

- `L2NORM_TKEEP_EN`
  - Defined: lanes are masked by `io_in_tkeep` as described above.
  - Undefined: `io_in_tkeep` is ignored, and every lane of every accepted beat is accumulated.

## Test plan

Bench defaults: `LANES`=4, `ELEM_W`=16, `ACC_W`=40.

- **Single beat:** lanes {3,4,0,0}, `tlast`=1, `io_out_tready`=1 → `tdata`=5, `tuser`=0, `tlast`=1. `tvalid` rises 21 edges after acceptance, and `io_in_tready` is 0 in between.
- **Multi-beat with negatives:** beats {-6,0,0,0}, {0,8,0,0} (`tlast` on the second) → `tdata`=10. Also run {1,1,1,1}×2 → `tdata`=2 (floor of sqrt 8).
- **Backpressure:** `io_out_tready`=0 for 10 cycles after `tvalid` → `tdata`, `tuser` and `tvalid` are held, and `io_in_tready`=0. Release → handshake, and `io_in_tready`=1 on the next cycle.
- **Saturation:** 256 beats of {-32768 ×4} → accumulator pinned at 2^40-1, `tdata`=0x000FFFFF, `tuser`=1. The next packet {3,4,0,0} gives `tuser`=0.
- **Keep mask:** lanes {3,4,100,100} with `tkeep`=8'h0F → `tdata`=5 with `L2NORM_TKEEP_EN` defined, 141 without it.
- **Mid-op reset:** assert `reset` for 1 cycle during SQRT → all outputs are at reset values immediately and no result is emitted. The next packet {0,0,0,5} gives `tdata`=5.
